// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder controller.
package nibble_serial_add_ctrl_pkg;

  // Width of one adder slice.
  localparam int NIBBLE_W = 4;

  // Controller states; encodings are fixed so they read the same in waves.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_add_ctrl_four_bit_adder.sv
// Purely combinational 4-bit ripple-carry adder, shared by the controller
// across all slices of a wide operand.
module four_bit_adder
  import nibble_serial_add_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);

  logic [NIBBLE_W:0] c;

  // Bitwise ripple: each full adder passes its carry to the next bit.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  assign cout = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial add sequencer: accepts a wide (a, b, cin) job, walks one
// 4-bit slice per cycle through a single four_bit_adder, LSB slice first,
// and returns {cout, sum} over a valid/ready handshake.
module nibble_serial_add_ctrl
  import nibble_serial_add_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*NIBBLES-1:0]    a,
  input  logic [4*NIBBLES-1:0]    b,
  input  logic                    cin,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*NIBBLES-1:0]    sum,
  output logic                    cout,
  output logic                    busy
);

  localparam int W     = NIBBLE_W * NIBBLES;
  // One spare bit so idx never wraps inside a job, even for NIBBLES a power of 2.
  localparam int IDX_W = $clog2(NIBBLES) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  if (NIBBLES < 1 || NIBBLES > 16) begin : g_bad_param
    $error("NIBBLES must be in 1..16");
  end

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic [W-1:0]      sum_q, sum_d;
  logic              cout_q, cout_d;

  logic [NIBBLE_W-1:0] a_sl, b_sl, add_s;
  logic                add_co;

  // Select the current slice of the captured operands.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (idx_q == IDX_W'(n)) begin
        a_sl = a_q[n*NIBBLE_W +: NIBBLE_W];
        b_sl = b_q[n*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  four_bit_adder u_add (
    .a    (a_sl),
    .b    (b_sl),
    .cin  (carry_q),
    .s    (add_s),
    .cout (add_co)
  );

  // Next-state logic: accept in IDLE, one slice per cycle in RUN, hold in DONE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int n = 0; n < NIBBLES; n++) begin
          if (idx_q == IDX_W'(n)) sum_d[n*NIBBLE_W +: NIBBLE_W] = add_s;
        end
        carry_d = add_co;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          cout_d  = add_co;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Ready is masked by reset so no job looks acceptable while held in reset.
  assign in_ready  = rst_n & (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) | (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Scoreboard bench for nibble_serial_add_ctrl with NIBBLES=4.
module tb_nibble_serial_add_ctrl;

  logic        clk, rst_n;
  logic        in_valid, in_ready;
  logic [15:0] a, b;
  logic        cin;
  logic        out_valid, out_ready;
  logic [15:0] sum;
  logic        cout, busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [16:0] exp_q[$];

  nibble_serial_add_ctrl #(.NIBBLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every completed output handshake is checked against the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got %0h with no job expected", {cout, sum});
        end else begin
          logic [16:0] e;
          e = exp_q.pop_front();
          if ({cout, sum} !== e) begin
            errors++;
            $display("FAIL sb_result: got %0h expected %0h", {cout, sum}, e);
          end
        end
      end
    end
  end

  // Offer a job and wait (bounded) for it to be accepted; returns the accept cycle.
  task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                      input logic [16:0] exp, input bit push, input bit hold,
                      output int acc);
    int n;
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      acc = -1;
    end else begin
      @(posedge clk);
      if (push) exp_q.push_back(exp);
      #1;
      acc = cyc;
      if (!hold) in_valid = 1'b0;
    end
  endtask

  task automatic wait_out_valid();
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("wait_out_valid", 32'(out_valid), 32'd1);
  endtask

  initial begin
    int acc, prev;
    logic [15:0] ra, rb;
    logic        rc;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;

    // Reset values
    #12;
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_sum",       32'(sum),       32'd0);
    chk("rst_cout",      32'(cout),      32'd0);
    @(posedge clk); #1; rst_n = 1'b1; #1;
    chk("rel_in_ready",  32'(in_ready),  32'd1);

    // 1) small add and latency
    send(16'h0002, 16'h000A, 1'b0, 17'h0000C, 1'b1, 1'b0, acc);
    chk("t1_busy", 32'(busy), 32'd1);
    repeat (3) @(posedge clk);
    #1 chk("t1_lat_early", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("t1_lat_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;

    // 2) carry ripples through every slice
    send(16'hFFFF, 16'h0001, 1'b0, 17'h10000, 1'b1, 1'b0, acc);
    wait_out_valid();
    @(posedge clk); #1;

    // 3) in_valid held and operands changed mid-job
    send(16'h1234, 16'h4321, 1'b1, 17'h05556, 1'b1, 1'b1, acc);
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t3_in_ready_low", 32'(in_ready), 32'd0);
      if (i < 4) begin @(posedge clk); #1; end
    end
    chk("t3_out_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("t3_idle_again", 32'(in_ready), 32'd1);

    // 4) consumer stalls the result
    out_ready = 1'b0;
    send(16'h8000, 16'h8000, 1'b0, 17'h10000, 1'b1, 1'b0, acc);
    wait_out_valid();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t4_hold_valid", 32'(out_valid), 32'd1);
      chk("t4_hold_res",   32'({cout, sum}), 32'h10000);
      chk("t4_in_ready",   32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t4_in_ready_back", 32'(in_ready), 32'd1);
    chk("t4_valid_gone",    32'(out_valid), 32'd0);

    // 5) reset in the second RUN cycle aborts the job
    send(16'h1111, 16'h2222, 1'b0, 17'h0, 1'b0, 1'b0, acc);
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_sum",       32'(sum),       32'd0);
    chk("t5_cout",      32'(cout),      32'd0);
    chk("t5_busy",      32'(busy),      32'd0);
    chk("t5_in_ready",  32'(in_ready),  32'd0);
    @(posedge clk); #1; rst_n = 1'b1; #1;
    chk("t5_rel_ready", 32'(in_ready), 32'd1);
    send(16'h00FF, 16'h0001, 1'b0, 17'h00100, 1'b1, 1'b0, acc);
    wait_out_valid();
    @(posedge clk); #1;

    // 6) back-to-back random jobs with fixed period
    out_ready = 1'b1;
    prev = 0;
    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom_range(0, 1));
      send(ra, rb, rc, 17'(ra) + 17'(rb) + 17'(rc), 1'b1, 1'b1, acc);
      if (i > 0) chk("t6_period", 32'(acc - prev), 32'd6);
      prev = acc;
    end
    in_valid = 1'b0;

    // Drain outstanding expectations
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(posedge clk);
    #1 chk("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
